sdpb_stream_fifo: RTL and testbench
===================================

# sdpb_stream_fifo

Parametrised single-clock FIFO built on one inferred simple-dual-port block RAM. It is the next generation of the fixed 1024×16 SDPB wrappers, with generic width and depth, an optional output pipeline stage, occupancy flags, and error pulses. It sits between line-rate producers and consumers in the tracking datapath, where a bare RAM wrapper forced every user to hand-roll pointer logic.

## Interface
- DATA_W, 16, word width in bits (1..36)
- ADDR_W, 10, address width; depth = 2^ADDR_W words (4..14)
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- AFULL_TH, 2^ADDR_W-4, almost_full asserts when level >= AFULL_TH
- AEMPTY_TH, 4, almost_empty asserts when level <= AEMPTY_TH

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read request
- rd_data  out  DATA_W  read word, qualified by rd_valid
- rd_valid  out  1  one-cycle pulse per accepted read
- full / empty  out  1  occupancy flags
- almost_full / almost_empty  out  1  threshold flags
- level  out  ADDR_W+1  words stored, 0..2^ADDR_W
- overflow / underflow  out  1  one-cycle pulse on a rejected write or read
- hwm  out  ADDR_W+1  high-water mark (see Configuration)

## Operation
- Write is accepted iff wr_en && !full. It stores wr_data at wr_ptr, and wr_ptr increments modulo 2^ADDR_W.
- Read is accepted iff rd_en && !empty. It reads at rd_ptr, and rd_ptr increments modulo 2^ADDR_W.
- Full blocks writes even when a read occurs in the same cycle. That read is accepted and the write is rejected with overflow=1.
- Empty blocks reads even when a write occurs in the same cycle. That write is accepted and the read is rejected with underflow=1.
- Both ops accepted in the same cycle: level is unchanged, and both pointers advance.
- level tracks accepted operations: +1 for a write only, -1 for a read only, 0 for both or neither.
- Flags derive from next-state level and are registered: full = (level==2^ADDR_W), empty = (level==0).
- Rejected ops change no state other than the error pulse.
- Because writes are blocked when full, a write never targets the address being read. No read-during-write collision handling is needed.
- rd_data holds its last value between reads.
- Reset clears the pointers and level. RAM contents are not cleared.

## Timing
- Reset values: rd_data=0, rd_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, level=0, overflow=0, underflow=0, hwm=0.
- Read latency with OUT_REG=0: read accepted at cycle N gives rd_data/rd_valid at N+1.
- Read latency with OUT_REG=1: the same read gives rd_data/rd_valid at N+2. The pipeline register is also cleared by reset.
- Flags and level update in the cycle after the accepted op (registered).
- A word written at cycle N is readable from cycle N+1 (empty deasserts at N+1).
- overflow/underflow assert in the cycle after the rejected request, for 1 cycle per rejected request.
- Back-to-back reads sustain one word per clock.
- Reset mid-operation: reads in flight in the OUT_REG pipeline are dropped, and rd_valid stays 0 in the cycle after reset.

## Configuration
- Macro: SDPB_STREAM_FIFO_HWM_EN.
- Defined: hwm is a register holding the maximum level since reset. It updates in the same cycle as level, and only reset clears it.
- Undefined: hwm is tied to 0 and no compare logic is generated. The port remains present.

## Test plan
- Fill and drain, DATA_W=16, ADDR_W=4:
  - Write 0x0001..0x0010 -> full=1 and level=16 the cycle after the 16th write.
  - Read 16 -> data 0x0001..0x0010 in order, empty=1 after the last read.
- Overflow: with the FIFO full, pulse wr_en=1 with data 0xBEEF -> overflow=1 for 1 cycle, level stays 16, and 0xBEEF never appears on rd_data.
- Underflow and simultaneous ops:
  - Empty FIFO, rd_en=1 && wr_en=1 (0x1234) -> underflow=1 and level=1; the next read returns 0x1234.
  - Full FIFO with rd_en && wr_en -> read accepted, overflow=1, level=15.
- Latency:
  - OUT_REG=0: rd_en accepted at cycle N -> rd_valid at N+1.
  - OUT_REG=1: rd_valid at N+2.
  - Continuous rd_en over 8 words -> 8 consecutive rd_valid pulses.
- Wrap-around: 40 interleaved write/read pairs at depth 16 -> data order preserved across 2+ pointer wraps; almost_full asserts at level 12 and almost_empty deasserts at level 5.
- Reset and HWM:
  - Fill to 10, read to 3, with SDPB_STREAM_FIFO_HWM_EN defined -> hwm=10.
  - Assert reset with a read in flight -> all outputs return to reset values, and rd_valid=0 the next cycle.

Source files
------------

// File: rtl/sdpb_stream_fifo.sv
// Single-clock FIFO on one inferred simple-dual-port block RAM, with occupancy and threshold flags, error pulses and an optional output stage.
// Optional high-water mark tracking is enabled by defining SDPB_STREAM_FIFO_HWM_EN.
module sdpb_stream_fifo #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int OUT_REG   = 0,
  parameter int AFULL_TH  = (1 << ADDR_W) - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   hwm
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AFULL_L  = AFULL_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] AEMPTY_L = AEMPTY_TH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_L    = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic [ADDR_W:0]   level_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              afull_r;
  logic              aempty_r;
  logic              ovf_r;
  logic              unf_r;
  logic [DATA_W-1:0] ram_q_r;
  logic              ram_v_r;
  logic              wr_acc_s;
  logic              rd_acc_s;

  // Accept decisions and next occupancy; full blocks writes even when a read frees a slot this cycle
  always_comb begin
    wr_acc_s    = wr_en & ~full_r;
    rd_acc_s    = rd_en & ~empty_r;
    level_nxt_s = level_r;
    if (wr_acc_s && !rd_acc_s) begin
      level_nxt_s = level_r + ONE_L;
    end else if (!wr_acc_s && rd_acc_s) begin
      level_nxt_s = level_r - ONE_L;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // RAM write port; left without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // RAM read port; data holds between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_q_r <= {DATA_W{1'b0}};
      ram_v_r <= 1'b0;
    end else begin
      ram_v_r <= rd_acc_s;
      if (rd_acc_s) begin
        ram_q_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Pointers, occupancy, registered flags and one-cycle error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {ADDR_W{1'b0}};
      rd_ptr_r <= {ADDR_W{1'b0}};
      level_r  <= {(ADDR_W+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      level_r  <= level_nxt_s;
      full_r   <= (level_nxt_s == DEPTH_L);
      empty_r  <= (level_nxt_s == {(ADDR_W+1){1'b0}});
      afull_r  <= (level_nxt_s >= AFULL_L);
      aempty_r <= (level_nxt_s <= AEMPTY_L);
      ovf_r    <= wr_en & full_r;
      unf_r    <= rd_en & empty_r;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] out_q_r;
      logic              out_v_r;
      // Extra output stage; reset drops any read still in flight
      always_ff @(posedge clk) begin
        if (reset) begin
          out_q_r <= {DATA_W{1'b0}};
          out_v_r <= 1'b0;
        end else begin
          out_v_r <= ram_v_r;
          if (ram_v_r) begin
            out_q_r <= ram_q_r;
          end
        end
      end
      assign rd_data  = out_q_r;
      assign rd_valid = out_v_r;
    end else begin : g_no_out_reg
      assign rd_data  = ram_q_r;
      assign rd_valid = ram_v_r;
    end
  endgenerate

`ifdef SDPB_STREAM_FIFO_HWM_EN
  logic [ADDR_W:0] hwm_r;
  // Peak occupancy since reset, tracked alongside level
  always_ff @(posedge clk) begin
    if (reset) begin
      hwm_r <= {(ADDR_W+1){1'b0}};
    end else if (level_nxt_s > hwm_r) begin
      hwm_r <= level_nxt_s;
    end
  end
  assign hwm = hwm_r;
`else
  assign hwm = {(ADDR_W+1){1'b0}};
`endif

  assign level        = level_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_sdpb_stream_fifo.sv
// Bench for sdpb_stream_fifo: a queue-based reference model checks two instances (read latency 1 and 2) driven by the same stimulus.
module tb_sdpb_stream_fifo;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1, full0, full1, empty0, empty1;
  logic          afull0, afull1, aempty0, aempty1, ovf0, ovf1, unf0, unf1;
  logic [AW:0]   level0, level1, hwm0, hwm1;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] last0, last1, pend_d;
  bit            pend_v;
  int            max_lvl;

  always #5 clk = ~clk;

  sdpb_stream_fifo #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(afull0), .almost_empty(aempty0), .level(level0),
    .overflow(ovf0), .underflow(unf0), .hwm(hwm0));

  sdpb_stream_fifo #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(afull1), .almost_empty(aempty1), .level(level1),
    .overflow(ovf1), .underflow(unf1), .hwm(hwm1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output of both instances.
  task automatic step(input bit rst, input bit we, input logic [DW-1:0] wd, input bit re);
    bit            wa, ra, ovf, unf, ev0, ev1;
    logic [DW-1:0] popped;
    int            lvl, ehwm;
    reset = rst; wr_en = we; wr_data = wd; rd_en = re;
    popped = '0; ovf = 1'b0; unf = 1'b0; ev0 = 1'b0; ev1 = 1'b0;
    @(posedge clk); #1;
    if (rst) begin
      q.delete();
      last0 = '0; last1 = '0; pend_v = 1'b0; pend_d = '0; max_lvl = 0;
    end else begin
      ovf = we && (q.size() == DEPTH);
      unf = re && (q.size() == 0);
      wa  = we && !ovf;
      ra  = re && !unf;
      ev1 = pend_v;
      if (pend_v) last1 = pend_d;
      if (ra) begin
        popped = q.pop_front();
        last0  = popped;
      end
      if (wa) q.push_back(wd);
      pend_v = ra;
      pend_d = popped;
      ev0    = ra;
      if (q.size() > max_lvl) max_lvl = q.size();
    end
    lvl = q.size();
`ifdef SDPB_STREAM_FIFO_HWM_EN
    ehwm = max_lvl;
`else
    ehwm = 0;
`endif
    chk("rd_valid0", 32'(rd_valid0), 32'(ev0));
    chk("rd_data0",  32'(rd_data0),  32'(last0));
    chk("rd_valid1", 32'(rd_valid1), 32'(ev1));
    chk("rd_data1",  32'(rd_data1),  32'(last1));
    chk("level0",    32'(level0),    32'(lvl));
    chk("level1",    32'(level1),    32'(lvl));
    chk("full0",     32'(full0),     32'(lvl == DEPTH));
    chk("full1",     32'(full1),     32'(lvl == DEPTH));
    chk("empty0",    32'(empty0),    32'(lvl == 0));
    chk("empty1",    32'(empty1),    32'(lvl == 0));
    chk("afull0",    32'(afull0),    32'(lvl >= DEPTH - 4));
    chk("afull1",    32'(afull1),    32'(lvl >= DEPTH - 4));
    chk("aempty0",   32'(aempty0),   32'(lvl <= 4));
    chk("aempty1",   32'(aempty1),   32'(lvl <= 4));
    chk("overflow0", 32'(ovf0),      32'(ovf));
    chk("overflow1", 32'(ovf1),      32'(ovf));
    chk("underflow0", 32'(unf0),     32'(unf));
    chk("underflow1", 32'(unf1),     32'(unf));
    chk("hwm0",      32'(hwm0),      32'(ehwm));
    chk("hwm1",      32'(hwm1),      32'(ehwm));
  endtask

  initial begin
    logic [DW-1:0] d;
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    last0 = '0; last1 = '0; pend_d = '0; pend_v = 1'b0; max_lvl = 0;

    // Reset values
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);

    // Fill 0x0001..0x0010
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 16'(i), 1'b0);
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_level", 32'(level0), 32'd16);

    // Overflow while full; 0xBEEF must never come out
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    chk("ovf_pulse", 32'(ovf0), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("ovf_one_cycle", 32'(ovf0), 32'd0);

    // Full with simultaneous read and write: read wins, write rejected
    step(1'b0, 1'b1, 16'h5555, 1'b1);
    chk("full_rw_level", 32'(level0), 32'd15);
    chk("full_rw_ovf", 32'(ovf0), 32'd1);

    // Continuous drain of the remaining 15 words, then two idle cycles
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("drain_empty", 32'(empty0), 32'd1);
    chk("drain_last", 32'(rd_data0), 32'h0010);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);

    // Empty with simultaneous read and write
    step(1'b0, 1'b1, 16'h1234, 1'b1);
    chk("empty_rw_unf", 32'(unf0), 32'd1);
    chk("empty_rw_level", 32'(level0), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("empty_rw_data", 32'(rd_data0), 32'h1234);
    step(1'b0, 1'b0, 16'h0000, 1'b0);

    // Eight words back to back
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);

    // Interleaved write/read pairs across several pointer wraps
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      step(1'b0, 1'b1, d, 1'b0);
      step(1'b0, 1'b0, 16'h0000, 1'b1);
    end

    // Random traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 400; i++) begin
      bit we, re;
      if ((i / 50) % 2 == 0) begin
        we = ($urandom_range(0, 99) < 70);
        re = ($urandom_range(0, 99) < 35);
      end else begin
        we = ($urandom_range(0, 99) < 35);
        re = ($urandom_range(0, 99) < 70);
      end
      step(1'b0, we, 16'($urandom), re);
    end

    // High-water mark: fill to 10, read down to 3
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("hwm_level", 32'(level0), 32'd3);
`ifdef SDPB_STREAM_FIFO_HWM_EN
    chk("hwm_peak", 32'(hwm0), 32'd10);
`else
    chk("hwm_tied", 32'(hwm0), 32'd0);
`endif

    // Reset with a read in flight, then a read attempt right after
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("rst_valid1", 32'(rd_valid1), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("post_rst_valid0", 32'(rd_valid0), 32'd0);
    chk("post_rst_valid1", 32'(rd_valid1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
